// File: rtl/intr_ctrl.sv
// Interrupt controller: per-channel edge/level capture into a pending register,
// fixed lowest-index priority, and a REQ/ACK/DONE handshake with the CPU.
module intr_ctrl #(
    parameter int                NUM_CH    = 8,
    parameter logic [NUM_CH-1:0] TRIG_EDGE = {NUM_CH{1'b1}},
    localparam int               ID_W      = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NUM_CH-1:0] irq_in_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic              gie_i,
    input  logic              int_ack_i,
    input  logic              int_done_i,
    output logic              int_req_o,
    output logic [ID_W-1:0]   int_id_o,
    output logic              int_active_o,
    output logic [NUM_CH-1:0] pend_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] set_vec, clr_vec, elig;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   win_id;
    logic              int_req_q, int_active_q;

    // Edge channels fire on a 0->1 transition, level channels on every high cycle.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_set
        if (TRIG_EDGE[gi]) begin : g_edge
            assign set_vec[gi] = irq_in_i[gi] & ~prev_q[gi];
        end else begin : g_level
            assign set_vec[gi] = irq_in_i[gi];
        end
    end

    assign clr_vec = (state_q == S_REQ && int_ack_i) ? (NUM_CH'(1) << id_q) : '0;
    // A set in the same cycle as the clear keeps the bit pending.
    assign pend_d  = (pend_q & ~clr_vec) | set_vec;
    assign elig    = pend_q & mask_i;

    always_comb begin
        win_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            S_IDLE: begin
                if (gie_i && (|elig)) begin
                    state_d = S_REQ;
                    id_d    = win_id;
                end
            end
            S_REQ: begin
                if (int_ack_i) begin
                    state_d = S_SVC;
                end else if (!gie_i) begin
                    state_d = S_IDLE;
                end
            end
            S_SVC: begin
                if (int_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // prev keeps tracking the lines during reset so a held line is not an edge.
        prev_q <= irq_in_i;
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            pend_q       <= '0;
            id_q         <= '0;
            int_req_q    <= 1'b0;
            int_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            id_q         <= id_d;
            int_req_q    <= (state_d == S_REQ);
            int_active_q <= (state_d == S_SVC);
        end
    end

    assign int_req_o    = int_req_q;
    assign int_active_o = int_active_q;
    assign int_id_o     = id_q;
    assign pend_o       = pend_q;

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8, SHALL set the number of interrupt channels (legal range 2-32).
REQ-002 Parameter TRIG_EDGE, default {NUM_CH{1'b1}}, SHALL set the per-channel trigger mode (bit i = 1: rising-edge channel; 0: level channel).
REQ-003 Localparam ID_W SHALL equal $clog2(NUM_CH).
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  SHALL be the synchronous, active-low reset.
REQ-006 IRQ_IN  input  NUM_CH  SHALL carry device request lines, already synchronous to CLK.
REQ-007 MASK  input  NUM_CH  SHALL carry per-channel enables (1 = channel may request).
REQ-008 GIE  input  1  SHALL be the global interrupt enable.
REQ-009 INT_ACK  input  1  SHALL be the CPU acknowledge of the current request.
REQ-010 INT_DONE  input  1  SHALL be the CPU end-of-service strobe (return from ISR).
REQ-011 INT_REQ  output  1  SHALL be the interrupt request to the CPU.
REQ-012 INT_ID  output  ID_W  SHALL be the index of the channel being requested or serviced.
REQ-013 INT_ACTIVE  output  1  SHALL be high while an ISR is in service.
REQ-014 PEND  output  NUM_CH  SHALL expose the pending register.

Function
REQ-015 An internal register PREV SHALL hold IRQ_IN from the previous cycle.
REQ-016 Edge channel i SHALL set PEND[i] at the clock edge where IRQ_IN[i]=1 and PREV[i]=0.
REQ-017 Level channel i SHALL set PEND[i] at every clock edge where IRQ_IN[i]=1.
REQ-018 PEND bits SHALL be set regardless of MASK and GIE; masking gates requests only.
REQ-019 PEND[INT_ID] SHALL clear at the clock edge where the FSM is in REQ and INT_ACK=1.
REQ-020 A set condition and a clear on the same bit in the same cycle SHALL leave the bit set.
REQ-021 A level channel still high after acknowledge SHALL therefore re-pend on the next cycle.
REQ-022 Eligible set E SHALL be PEND & MASK; the winner SHALL be the lowest-index bit of E.
REQ-023 FSM states: IDLE, REQ, SVC.
REQ-024 IDLE -> REQ when GIE=1 and E nonzero; INT_ID SHALL load the winner on that edge.
REQ-025 Latency: INT_REQ SHALL assert exactly one cycle after the PEND bit becomes visible.
REQ-026 In REQ: INT_REQ=1; INT_ID SHALL stay stable even if a higher-priority channel pends.
REQ-027 REQ -> SVC on INT_ACK=1.
REQ-028 REQ -> IDLE with INT_ACK=0 and GIE=0 (request withdrawn, PEND unchanged).
REQ-029 When INT_ACK=1 and GIE=0 in the same cycle in REQ, INT_ACK SHALL win.
REQ-030 In SVC: INT_REQ=0, INT_ACTIVE=1, INT_ID held; no nesting; new pends accumulate.
REQ-031 SVC -> IDLE on INT_DONE=1; INT_DONE SHALL be ignored outside SVC and INT_ACK outside REQ.
REQ-032 From IDLE after SVC, re-arbitration SHALL take one cycle (back-to-back requests gap >= 1 cycle).
REQ-033 INT_REQ and INT_ACTIVE SHALL be registered outputs, never both high.

Reset
REQ-034 With RST_N=0 at a clock edge: state=IDLE, PEND=0, INT_REQ=0, INT_ACTIVE=0, INT_ID=0.
REQ-035 During reset PREV SHALL load IRQ_IN, so a line already high at release produces no edge.
REQ-036 Reset asserted in any state (including REQ or SVC) SHALL abort the operation and drop all pending requests.

Verification (NUM_CH=8, TRIG_EDGE=8'h0F)
REQ-037 MASK=FF, GIE=1, IRQ_IN[2] 0->1 -> PEND=04 next edge, INT_REQ=1 with INT_ID=2 one cycle later.
REQ-038 IRQ_IN[5] and IRQ_IN[1] rise together -> INT_ID=1 first; after ACK and DONE, INT_ID=5.
REQ-039 Level channel 6 held high, acknowledged -> PEND[6] back to 1 one cycle after the ACK edge.
REQ-040 Edge on ch3 in the same cycle as ACK of ch3 -> PEND[3] stays 1 and a second REQ for ch3 follows SVC.
REQ-041 MASK=00 with an edge on ch0 -> PEND=01, INT_REQ stays 0; setting MASK=01 -> INT_REQ next cycle.
REQ-042 RST_N=0 while in SVC with IRQ_IN[0] held high -> all outputs 0; after release, no request from ch0.
